k423_mem_port_arbiter: RTL and testbench
========================================

// Module: k423_mem_port_arbiter
// PURPOSE
//  Shares the core's single memory bus port between instruction fetch (IF) and the load/store path (LSU).
//  Accepts one request at a time and registers it onto the bus.
//  Tracks which requester owns the single outstanding transaction and routes the response
//  (the rdata consumed by the mem stage for LSU) back to it.
//  Adds fetch-flush response dropping and a response timeout.
// PARAMETERS
//  ADDR_W      `CORE_ADDR_W  request address width
//  DATA_W      `CORE_FETCH_W data/rdata width; WSTRB width = DATA_W/8
//  STARVE_LIM  4             consecutive LSU grants while IF waits before IF is forced a grant (>=1)
//  TIMEOUT_CYC 255           WAIT cycles without bus_rsp_vld_i before error response (>=2)
// PORTS
//  clk_i           in  1        clock
//  rst_n_i         in  1        asynchronous active-low reset
//  if_req_vld_i    in  1        IF read request valid
//  if_req_rdy_o    out 1        IF request accepted when vld&rdy
//  if_req_addr_i   in  ADDR_W   IF fetch address
//  if_flush_i      in  1        branch redirect: discard pending IF response
//  if_rsp_vld_o    out 1        IF response valid (1 cycle)
//  if_rsp_rdata_o  out DATA_W   IF response data
//  if_rsp_err_o    out 1        IF response is timeout error
//  lsu_req_vld_i   in  1        LSU request valid
//  lsu_req_rdy_o   out 1        LSU request accepted when vld&rdy
//  lsu_req_addr_i  in  ADDR_W   LSU address (word-aligned, byte select by wstrb/mem stage)
//  lsu_req_wen_i   in  1        1 = store, 0 = load
//  lsu_req_wdata_i in  DATA_W   store data
//  lsu_req_wstrb_i in  DATA_W/8 store byte enables
//  lsu_rsp_vld_o   out 1        LSU response valid (1 cycle; stores also respond)
//  lsu_rsp_rdata_o out DATA_W   load data, raw word
//  lsu_rsp_err_o   out 1        LSU response is timeout error
//  bus_req_vld_o   out 1        bus request valid
//  bus_req_rdy_i   in  1        bus accepts request
//  bus_req_addr_o  out ADDR_W   registered address
//  bus_req_wen_o   out 1        registered write enable (0 for IF)
//  bus_req_wdata_o out DATA_W   registered write data (0 for IF)
//  bus_req_wstrb_o out DATA_W/8 registered byte enables (0 for IF)
//  bus_rsp_vld_i   in  1        bus response valid
//  bus_rsp_rdata_i in  DATA_W   bus response data
// BEHAVIOUR
//  - FSM IDLE -> REQ -> WAIT -> IDLE. Exactly one transaction outstanding.
//  - Reset: state IDLE, owner=IF, drop=0, starve_cnt=0, tmo_cnt=0; all bus_req_* regs 0.
//    All rsp outputs 0. Ready outputs follow IDLE rules immediately after reset.
//  - IDLE ready rules:
//      lsu_req_rdy_o = ~force_if.
//      if_req_rdy_o  = ~lsu_req_vld_i | force_if.
//      force_if      = (starve_cnt == STARVE_LIM) & if_req_vld_i.
//  - Ready outputs are 0 in REQ and WAIT.
//  - Accept (vld&rdy) in IDLE at cycle N:
//      latch addr/wen/wdata/wstrb (IF: wen=0, wdata=0, wstrb=0); set owner; drop=0.
//      Go to REQ. bus_req_vld_o=1 from cycle N+1.
//  - REQ: hold bus_req_* stable until bus_req_rdy_i; then go to WAIT with tmo_cnt=0.
//    No timeout in REQ.
//  - WAIT: on bus_rsp_vld_i, in the same cycle:
//      assert owner's rsp_vld_o (unless owner=IF & drop);
//      rdata = bus_rsp_rdata_i, err = 0; go to IDLE.
//    Earliest new accept is the cycle after the response.
//  - Timeout: tmo_cnt increments each WAIT cycle without a response.
//    On the cycle tmo_cnt == TIMEOUT_CYC-1 with no rsp: owner rsp_vld_o=1, err=1, rdata=0; go to IDLE.
//  - bus_rsp_vld_i is ignored outside WAIT (late or stray responses are dropped).
//  - Unselected rsp outputs are 0. rsp outputs are combinational from state/owner/bus_rsp.
//  - Flush: if_flush_i in REQ/WAIT with owner=IF sets drop. The transaction still completes on the bus.
//    The IF response (including timeout) is suppressed.
//    if_flush_i in IDLE or with owner=LSU has no effect. A flush on the response cycle suppresses that response.
//  - Starvation counter:
//      LSU grant while if_req_vld_i: starve_cnt+1, saturating at STARVE_LIM.
//      IF grant: clear to 0.
//      Otherwise: hold.
//  - Simultaneous IF+LSU valid in IDLE: LSU wins unless force_if.
//  - Requesters may drop vld without handshake; no state change.
// TESTING
//  - Reset mid-WAIT (LSU load 0x100 outstanding) -> state IDLE, bus_req_vld_o=0, no lsu_rsp.
//    Late bus_rsp_vld_i ignored.
//  - IF 0x80 alone, bus_req_rdy_i=1, rsp 3 cycles later with 0xDEADBEEF.
//    -> bus_req_vld_o 1 cycle after accept, addr 0x80, wen=0; if_rsp_vld_o=1 with 0xDEADBEEF.
//  - IF and LSU store (0x200, wdata 0x11223344, wstrb 4'b0011) both valid.
//    -> LSU granted, bus_req_wen_o=1, wstrb 0011; lsu_rsp_vld_o on rsp; IF granted next IDLE.
//  - LSU valid continuously with IF valid, STARVE_LIM=4 -> grants LSU,LSU,LSU,LSU,IF.
//    starve_cnt back to 0.
//  - IF request accepted, if_flush_i pulsed in WAIT, rsp arrives -> if_rsp_vld_o stays 0; FSM returns IDLE.
//  - LSU load, bus never responds, TIMEOUT_CYC=8 -> lsu_rsp_vld_o=1, err=1, rdata=0 on 8th WAIT cycle.
//    Next LSU request accepted.

Source files
------------

// File: rtl/k423_mem_port_arbiter.sv
// Arbitrates the single memory bus port between instruction fetch and the LSU.
// One transaction outstanding; the response is routed back to the requester that owns it.
module k423_mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STARVE_LIM  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                if_req_vld_i,
  output logic                if_req_rdy_o,
  input  logic [ADDR_W-1:0]   if_req_addr_i,
  input  logic                if_flush_i,
  output logic                if_rsp_vld_o,
  output logic [DATA_W-1:0]   if_rsp_rdata_o,
  output logic                if_rsp_err_o,
  input  logic                lsu_req_vld_i,
  output logic                lsu_req_rdy_o,
  input  logic [ADDR_W-1:0]   lsu_req_addr_i,
  input  logic                lsu_req_wen_i,
  input  logic [DATA_W-1:0]   lsu_req_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb_i,
  output logic                lsu_rsp_vld_o,
  output logic [DATA_W-1:0]   lsu_rsp_rdata_o,
  output logic                lsu_rsp_err_o,
  output logic                bus_req_vld_o,
  input  logic                bus_req_rdy_i,
  output logic [ADDR_W-1:0]   bus_req_addr_o,
  output logic                bus_req_wen_o,
  output logic [DATA_W-1:0]   bus_req_wdata_o,
  output logic [DATA_W/8-1:0] bus_req_wstrb_o,
  input  logic                bus_rsp_vld_i,
  input  logic [DATA_W-1:0]   bus_rsp_rdata_i
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SC_W   = $clog2(STARVE_LIM + 1);
  localparam int unsigned TC_W   = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

  state_e            state_q, state_d;
  logic              owner_lsu_q, owner_lsu_d;
  logic              drop_q, drop_d;
  logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [TC_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic              req_vld_q, req_vld_d;
  bus_req_t          req_q, req_d;
  logic              force_if;
  logic              done;
  logic              deliver;

  assign force_if = (starve_cnt_q == SC_W'(STARVE_LIM)) & if_req_vld_i;

  assign bus_req_vld_o   = req_vld_q;
  assign bus_req_addr_o  = req_q.addr;
  assign bus_req_wen_o   = req_q.wen;
  assign bus_req_wdata_o = req_q.wdata;
  assign bus_req_wstrb_o = req_q.wstrb;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      owner_lsu_q  <= 1'b0;
      drop_q       <= 1'b0;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      req_vld_q    <= 1'b0;
      req_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_lsu_q  <= owner_lsu_d;
      drop_q       <= drop_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      req_vld_q    <= req_vld_d;
      req_q        <= req_d;
    end
  end

  // Response completes on bus data or on the last permitted WAIT cycle.
  assign done    = (state_q == ST_WAIT) &
                   (bus_rsp_vld_i | (tmo_cnt_q == TC_W'(TIMEOUT_CYC - 1)));
  assign deliver = done & (owner_lsu_q | ~(drop_q | if_flush_i));

  always_comb begin
    state_d         = state_q;
    owner_lsu_d     = owner_lsu_q;
    drop_d          = drop_q;
    starve_cnt_d    = starve_cnt_q;
    tmo_cnt_d       = tmo_cnt_q;
    req_vld_d       = req_vld_q;
    req_d           = req_q;
    if_req_rdy_o    = 1'b0;
    lsu_req_rdy_o   = 1'b0;
    if_rsp_vld_o    = 1'b0;
    if_rsp_rdata_o  = '0;
    if_rsp_err_o    = 1'b0;
    lsu_rsp_vld_o   = 1'b0;
    lsu_rsp_rdata_o = '0;
    lsu_rsp_err_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        lsu_req_rdy_o = ~force_if;
        if_req_rdy_o  = ~lsu_req_vld_i | force_if;
        if (lsu_req_vld_i && !force_if) begin
          state_d     = ST_REQ;
          owner_lsu_d = 1'b1;
          drop_d      = 1'b0;
          req_vld_d   = 1'b1;
          req_d       = '{addr: lsu_req_addr_i, wen: lsu_req_wen_i,
                          wdata: lsu_req_wdata_i, wstrb: lsu_req_wstrb_i};
          if (if_req_vld_i && (starve_cnt_q < SC_W'(STARVE_LIM))) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
          end
        end else if (if_req_vld_i) begin
          state_d      = ST_REQ;
          owner_lsu_d  = 1'b0;
          drop_d       = 1'b0;
          req_vld_d    = 1'b1;
          req_d        = '{addr: if_req_addr_i, wen: 1'b0, wdata: '0, wstrb: '0};
          starve_cnt_d = '0;
        end
      end
      ST_REQ: begin
        if (if_flush_i && !owner_lsu_q) drop_d = 1'b1;
        if (bus_req_rdy_i) begin
          state_d   = ST_WAIT;
          req_vld_d = 1'b0;
          tmo_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (if_flush_i && !owner_lsu_q) drop_d = 1'b1;
        if (done) begin
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Route the completed response to its owner; a timeout returns zero data.
    if (deliver) begin
      if (owner_lsu_q) begin
        lsu_rsp_vld_o   = 1'b1;
        lsu_rsp_rdata_o = bus_rsp_vld_i ? bus_rsp_rdata_i : '0;
        lsu_rsp_err_o   = ~bus_rsp_vld_i;
      end else begin
        if_rsp_vld_o    = 1'b1;
        if_rsp_rdata_o  = bus_rsp_vld_i ? bus_rsp_rdata_i : '0;
        if_rsp_err_o    = ~bus_rsp_vld_i;
      end
    end
  end

endmodule

// File: tb/tb_k423_mem_port_arbiter.sv
// Bench for k423_mem_port_arbiter: directed scenarios plus random traffic,
// all checked each cycle against a transaction-level reference model.
module tb_k423_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;
  localparam int unsigned TC = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          if_req_vld_i, if_req_rdy_o, if_flush_i;
  logic [AW-1:0] if_req_addr_i;
  logic          if_rsp_vld_o, if_rsp_err_o;
  logic [DW-1:0] if_rsp_rdata_o;
  logic          lsu_req_vld_i, lsu_req_rdy_o, lsu_req_wen_i;
  logic [AW-1:0] lsu_req_addr_i;
  logic [DW-1:0] lsu_req_wdata_i;
  logic [3:0]    lsu_req_wstrb_i;
  logic          lsu_rsp_vld_o, lsu_rsp_err_o;
  logic [DW-1:0] lsu_rsp_rdata_o;
  logic          bus_req_vld_o, bus_req_rdy_i, bus_req_wen_o;
  logic [AW-1:0] bus_req_addr_o;
  logic [DW-1:0] bus_req_wdata_o;
  logic [3:0]    bus_req_wstrb_o;
  logic          bus_rsp_vld_i;
  logic [DW-1:0] bus_rsp_rdata_i;

  k423_mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(SL), .TIMEOUT_CYC(TC)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_vld_i(if_req_vld_i), .if_req_rdy_o(if_req_rdy_o), .if_req_addr_i(if_req_addr_i),
    .if_flush_i(if_flush_i), .if_rsp_vld_o(if_rsp_vld_o), .if_rsp_rdata_o(if_rsp_rdata_o),
    .if_rsp_err_o(if_rsp_err_o),
    .lsu_req_vld_i(lsu_req_vld_i), .lsu_req_rdy_o(lsu_req_rdy_o), .lsu_req_addr_i(lsu_req_addr_i),
    .lsu_req_wen_i(lsu_req_wen_i), .lsu_req_wdata_i(lsu_req_wdata_i),
    .lsu_req_wstrb_i(lsu_req_wstrb_i), .lsu_rsp_vld_o(lsu_rsp_vld_o),
    .lsu_rsp_rdata_o(lsu_rsp_rdata_o), .lsu_rsp_err_o(lsu_rsp_err_o),
    .bus_req_vld_o(bus_req_vld_o), .bus_req_rdy_i(bus_req_rdy_i), .bus_req_addr_o(bus_req_addr_o),
    .bus_req_wen_o(bus_req_wen_o), .bus_req_wdata_o(bus_req_wdata_o),
    .bus_req_wstrb_o(bus_req_wstrb_o), .bus_rsp_vld_i(bus_rsp_vld_i),
    .bus_rsp_rdata_i(bus_rsp_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 = free, 1 = request on bus, 2 = awaiting response.
  int            m_phase, m_starve, m_wait;
  bit            m_lsu, m_drop, m_bvld, m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;

  string         grants;
  int            n_if_rsp, n_lsu_rsp;
  logic [DW-1:0] last_rdata;
  logic          last_err;

  task automatic model_reset();
    m_phase = 0; m_starve = 0; m_wait = 0;
    m_lsu = 0; m_drop = 0; m_bvld = 0; m_wen = 0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0;
  endtask

  // Compare every output at the falling edge, then advance the model one cycle.
  task automatic step();
    bit            frc, lrdy, irdy, done, dlv, i_rsp, l_rsp, err;
    logic [DW-1:0] rd;
    @(negedge clk_i);
    frc  = (m_starve == SL) && if_req_vld_i;
    lrdy = (m_phase == 0) && !frc;
    irdy = (m_phase == 0) && (!lsu_req_vld_i || frc);
    done = (m_phase == 2) && (bus_rsp_vld_i || m_wait == TC - 1);
    dlv  = done && (m_lsu || !(m_drop || if_flush_i));
    i_rsp = dlv && !m_lsu;
    l_rsp = dlv && m_lsu;
    rd   = bus_rsp_vld_i ? bus_rsp_rdata_i : '0;
    err  = !bus_rsp_vld_i;

    chk("if_rdy", if_req_rdy_o, irdy);
    chk("lsu_rdy", lsu_req_rdy_o, lsu_req_vld_i ? lrdy : lrdy);
    chk("if_rsp_vld", if_rsp_vld_o, i_rsp);
    chk("if_rsp_rdata", if_rsp_rdata_o, i_rsp ? rd : '0);
    chk("if_rsp_err", if_rsp_err_o, i_rsp && err);
    chk("lsu_rsp_vld", lsu_rsp_vld_o, l_rsp);
    chk("lsu_rsp_rdata", lsu_rsp_rdata_o, l_rsp ? rd : '0);
    chk("lsu_rsp_err", lsu_rsp_err_o, l_rsp && err);
    chk("bus_vld", bus_req_vld_o, m_bvld);
    chk("bus_addr", bus_req_addr_o, m_addr);
    chk("bus_wen", bus_req_wen_o, m_wen);
    chk("bus_wdata", bus_req_wdata_o, m_wdata);
    chk("bus_wstrb", bus_req_wstrb_o, m_wstrb);

    if (if_req_vld_i && if_req_rdy_o) grants = {grants, "I"};
    if (lsu_req_vld_i && lsu_req_rdy_o) grants = {grants, "L"};
    if (if_rsp_vld_o) begin
      n_if_rsp++; last_rdata = if_rsp_rdata_o; last_err = if_rsp_err_o;
    end
    if (lsu_rsp_vld_o) begin
      n_lsu_rsp++; last_rdata = lsu_rsp_rdata_o; last_err = lsu_rsp_err_o;
    end

    if (lrdy && lsu_req_vld_i) begin
      m_phase = 1; m_lsu = 1; m_drop = 0; m_bvld = 1;
      m_addr = lsu_req_addr_i; m_wen = lsu_req_wen_i;
      m_wdata = lsu_req_wdata_i; m_wstrb = lsu_req_wstrb_i;
      if (if_req_vld_i && m_starve < SL) m_starve++;
    end else if (irdy && if_req_vld_i) begin
      m_phase = 1; m_lsu = 0; m_drop = 0; m_bvld = 1;
      m_addr = if_req_addr_i; m_wen = 0; m_wdata = '0; m_wstrb = '0;
      m_starve = 0;
    end else if (m_phase == 1) begin
      if (if_flush_i && !m_lsu) m_drop = 1;
      if (bus_req_rdy_i) begin
        m_phase = 2; m_wait = 0; m_bvld = 0;
      end
    end else if (m_phase == 2) begin
      if (if_flush_i && !m_lsu) m_drop = 1;
      if (done) m_phase = 0;
      else m_wait++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_vld_i = 0; lsu_req_vld_i = 0; if_flush_i = 0;
    bus_req_rdy_i = 1; bus_rsp_vld_i = 0;
  endtask

  // Complete whatever is outstanding with a prompt bus.
  task automatic drain();
    idle_inputs();
    bus_rsp_vld_i = 1;
    repeat (4) step();
    bus_rsp_vld_i = 0;
  endtask

  int n0;

  initial begin
    rst_n_i = 0;
    idle_inputs();
    if_req_addr_i = '0; lsu_req_addr_i = '0; lsu_req_wen_i = 0;
    lsu_req_wdata_i = '0; lsu_req_wstrb_i = '0; bus_rsp_rdata_i = '0;
    grants = ""; n_if_rsp = 0; n_lsu_rsp = 0; last_rdata = '0; last_err = 0;
    model_reset();
    #12;
    chk("rst_bus_vld", bus_req_vld_o, 0);
    chk("rst_bus_addr", bus_req_addr_o, 0);
    chk("rst_if_rsp", if_rsp_vld_o, 0);
    chk("rst_lsu_rdy", lsu_req_rdy_o, 1);
    rst_n_i = 1;
    @(posedge clk_i); #1;

    // IF fetch of 0x80 alone
    if_req_vld_i = 1; if_req_addr_i = 32'h80;
    step();
    chk("if80_bvld", bus_req_vld_o, 1);
    chk("if80_addr", bus_req_addr_o, 32'h80);
    chk("if80_wen", bus_req_wen_o, 0);
    if_req_vld_i = 0;
    n0 = n_if_rsp;
    repeat (3) step();
    bus_rsp_vld_i = 1; bus_rsp_rdata_i = 32'hDEADBEEF;
    step();
    bus_rsp_vld_i = 0;
    chk("if80_rsp_cnt", n_if_rsp - n0, 1);
    chk("if80_rdata", last_rdata, 32'hDEADBEEF);

    // IF and LSU store together: LSU first, IF next
    grants = "";
    if_req_vld_i = 1; if_req_addr_i = 32'h40;
    lsu_req_vld_i = 1; lsu_req_addr_i = 32'h200; lsu_req_wen_i = 1;
    lsu_req_wdata_i = 32'h11223344; lsu_req_wstrb_i = 4'b0011;
    step();
    lsu_req_vld_i = 0;
    chk("st_wen", bus_req_wen_o, 1);
    chk("st_wstrb", bus_req_wstrb_o, 4'b0011);
    n0 = n_lsu_rsp;
    step();
    bus_rsp_vld_i = 1; bus_rsp_rdata_i = 32'h5;
    step();
    bus_rsp_vld_i = 0;
    chk("st_rsp_cnt", n_lsu_rsp - n0, 1);
    step();
    chk("st_then_if", grants == "LI", 1);
    drain();

    // Starvation: four LSU grants then a forced IF grant, then LSU again
    grants = "";
    if_req_vld_i = 1; lsu_req_vld_i = 1; lsu_req_wen_i = 0;
    bus_req_rdy_i = 1; bus_rsp_vld_i = 1;
    repeat (18) step();
    chk("starve_order", grants == "LLLLIL", 1);
    drain();

    // Flush while IF waits: response suppressed
    if_req_vld_i = 1; if_req_addr_i = 32'h300;
    step();
    if_req_vld_i = 0;
    n0 = n_if_rsp;
    step();
    if_flush_i = 1; step();
    if_flush_i = 0; step();
    bus_rsp_vld_i = 1; step();
    bus_rsp_vld_i = 0;
    chk("flush_drop", n_if_rsp - n0, 0);
    chk("flush_idle_rdy", lsu_req_rdy_o, 1);

    // LSU load with no bus response: timeout on the 8th WAIT cycle
    lsu_req_vld_i = 1; lsu_req_addr_i = 32'h44; lsu_req_wen_i = 0;
    step();
    lsu_req_vld_i = 0;
    step();
    n0 = n_lsu_rsp;
    repeat (TC - 1) step();
    chk("tmo_early", n_lsu_rsp - n0, 0);
    step();
    chk("tmo_fire", n_lsu_rsp - n0, 1);
    chk("tmo_err", last_err, 1);
    chk("tmo_rdata", last_rdata, 0);
    lsu_req_vld_i = 1;
    step();
    chk("tmo_next_acc", bus_req_vld_o, 1);
    drain();

    // Reset while an LSU load of 0x100 is outstanding; late response ignored
    lsu_req_vld_i = 1; lsu_req_addr_i = 32'h100; lsu_req_wen_i = 0;
    step();
    lsu_req_vld_i = 0;
    repeat (2) step();
    rst_n_i = 0;
    model_reset();
    #1;
    chk("rstw_bus_vld", bus_req_vld_o, 0);
    chk("rstw_lsu_rsp", lsu_rsp_vld_o, 0);
    bus_rsp_vld_i = 1;
    #1;
    chk("rstw_stray", lsu_rsp_vld_o, 0);
    #1;
    rst_n_i = 1;
    n0 = n_lsu_rsp;
    step();
    step();
    bus_rsp_vld_i = 0;
    chk("rstw_late_rsp", n_lsu_rsp - n0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if_req_vld_i    = ($urandom_range(1, 0) == 1);
      if_req_addr_i   = $urandom;
      if_flush_i      = ($urandom_range(7, 0) == 0);
      lsu_req_vld_i   = ($urandom_range(1, 0) == 1);
      lsu_req_addr_i  = $urandom;
      lsu_req_wen_i   = ($urandom_range(1, 0) == 1);
      lsu_req_wdata_i = $urandom;
      lsu_req_wstrb_i = 4'($urandom);
      bus_req_rdy_i   = ($urandom_range(1, 0) == 1);
      bus_rsp_vld_i   = ($urandom_range(4, 0) == 0);
      bus_rsp_rdata_i = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
